// File: rtl/lock_pkg.sv
// -----------------------------------------------------------------------------
// lock_pkg
// Shared definitions for the keypad digit lock supervisor.
//   - digit width and the largest legal keypad digit
//   - stored-code width (up to eight 4-bit digits)
//   - FSM state encoding (ST_PROG is only reachable when LOCK_PROG_EN is defined)
//   - helpers to pick a code nibble and to flag non-decimal digits
// -----------------------------------------------------------------------------
package lock_pkg;

    localparam int DIGIT_W   = 4;
    localparam int DIGIT_MAX = 9;
    localparam int CODE_W    = 32;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_ENTRY    = 3'd1,
        ST_UNLOCKED = 3'd2,
        ST_LOCKOUT  = 3'd3,
        ST_PROG     = 3'd4
    } lock_state_e;

    // Nibble idx of the code word (nibble 0 = least significant).
    function automatic logic [DIGIT_W-1:0] code_nibble(input logic [CODE_W-1:0] code,
                                                       input logic [2:0]        idx);
        return DIGIT_W'(code >> {idx, 2'b00});
    endfunction

    // Keypad values 10..15 can never match a stored digit.
    function automatic logic digit_bad(input logic [DIGIT_W-1:0] d);
        return d > DIGIT_W'(DIGIT_MAX);
    endfunction

endpackage

// File: rtl/lock_timer.sv
// -----------------------------------------------------------------------------
// lock_timer
// Loadable down-counter with a zero flag. Load has priority over decrement;
// the counter holds at zero instead of wrapping.
// Ports:
//   clk        in   clock
//   reset      in   asynchronous active-high reset (count -> 0)
//   load_i     in   load load_val_i this cycle
//   load_val_i in   value to load
//   dec_i      in   decrement by one (ignored when already zero)
//   zero_o     out  count is zero
// -----------------------------------------------------------------------------
module lock_timer #(
    parameter int WIDTH = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_val_i,
    input  logic             dec_i,
    output logic             zero_o
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = load_val_i;
        end else if (dec_i && (count_q != '0)) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign zero_o = (count_q == '0);

endmodule

// File: rtl/lock_sequencer.sv
// -----------------------------------------------------------------------------
// lock_sequencer
// Supervisory controller for the keypad digit lock. Collects CODE_LEN digits,
// compares them with the stored code only after the last digit, counts
// consecutive failures, enforces a timed lockout after MAX_FAILS failures and
// relocks the door after RELOCK_CYCLES or on lock_req.
//
// Optional feature (macro LOCK_PROG_EN): adds input program_i. From UNLOCKED,
// program_i enters PROG; the next CODE_LEN digits replace the stored code.
// Without the macro the code is the CODE_DEFAULT constant.
//
// Input qualification: enter is a one-cycle strobe; digit is only looked at
// while enter is high. There is no back-pressure: strobes arriving while the
// FSM is in UNLOCKED or LOCKOUT are dropped.
//
// Ports:
//   clk          in   system clock
//   reset        in   asynchronous active-high reset
//   enter        in   digit strobe
//   digit        in   keypad digit (0..9; 10..15 always mismatch)
//   clear        in   abort current entry (wins over a same-cycle enter)
//   lock_req     in   immediate relock request (UNLOCKED / PROG only)
//   program_i    in   enter code programming (LOCK_PROG_EN only)
//   unlocked     out  door release, registered
//   locked_out   out  lockout active, registered
//   attempt_fail out  one-cycle pulse per failed attempt
//   fail_count   out  consecutive failures, saturating at MAX_FAILS
//   digit_count  out  digits accepted in the current entry
//   state_dbg    out  current FSM state
// -----------------------------------------------------------------------------
module lock_sequencer
    import lock_pkg::*;
#(
    parameter int          CODE_LEN       = 4,
    parameter logic [31:0] CODE_DEFAULT   = 32'h0000_9979,
    parameter int          MAX_FAILS      = 3,
    parameter int          LOCKOUT_CYCLES = 1000,
    parameter int          RELOCK_CYCLES  = 500
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         enter,
    input  logic [3:0]   digit,
    input  logic         clear,
    input  logic         lock_req,
`ifdef LOCK_PROG_EN
    input  logic         program_i,
`endif
    output logic         unlocked,
    output logic         locked_out,
    output logic         attempt_fail,
    output logic [3:0]   fail_count,
    output logic [2:0]   digit_count,
    output lock_state_e  state_dbg
);

    localparam int TMR_MAX = (LOCKOUT_CYCLES > RELOCK_CYCLES) ? LOCKOUT_CYCLES : RELOCK_CYCLES;
    localparam int TMR_W   = $clog2(TMR_MAX + 1);

    lock_state_e       state_q, state_d;
    logic              unlocked_q, unlocked_d;
    logic              locked_out_q, locked_out_d;
    logic              attempt_fail_q, attempt_fail_d;
    logic [3:0]        fail_count_q, fail_count_d;
    logic [2:0]        digit_count_q, digit_count_d;
    logic              mismatch_q, mismatch_d;

    logic [CODE_W-1:0] code_cur;
    logic [2:0]        cnt_eff;
    logic              flag_eff;
    logic              digit_mm;
    logic              final_mm;
    logic              last_digit;
    logic              prog_last;
    logic [3:0]        fail_inc;

    logic              timer_load;
    logic [TMR_W-1:0]  timer_load_val;
    logic              timer_dec;
    logic              timer_zero;

`ifdef LOCK_PROG_EN
    logic [CODE_W-1:0] code_q, code_d;
    logic [CODE_W-1:0] shadow_q, shadow_d;
    logic [CODE_W-1:0] shadow_next;

    assign code_cur = code_q;
`else
    assign code_cur = CODE_DEFAULT;
`endif

    // Relock and lockout never run together, so one counter serves both.
    lock_timer #(
        .WIDTH (TMR_W)
    ) u_timer (
        .clk        (clk),
        .reset      (reset),
        .load_i     (timer_load),
        .load_val_i (timer_load_val),
        .dec_i      (timer_dec),
        .zero_o     (timer_zero)
    );

    always_comb begin
        state_d        = state_q;
        unlocked_d     = unlocked_q;
        locked_out_d   = locked_out_q;
        attempt_fail_d = 1'b0;
        fail_count_d   = fail_count_q;
        digit_count_d  = digit_count_q;
        mismatch_d     = mismatch_q;
        timer_load     = 1'b0;
        timer_load_val = '0;
        timer_dec      = 1'b0;

        // In IDLE the entry starts fresh regardless of leftover counters.
        cnt_eff    = (state_q == ST_ENTRY) ? digit_count_q : 3'd0;
        flag_eff   = (state_q == ST_ENTRY) ? mismatch_q : 1'b0;
        // First digit entered is compared with the most significant used nibble.
        digit_mm   = digit_bad(digit) ||
                     (digit != code_nibble(code_cur, 3'(CODE_LEN - 1) - cnt_eff));
        final_mm   = flag_eff | digit_mm;
        last_digit = (cnt_eff == 3'(CODE_LEN - 1));
        prog_last  = (digit_count_q == 3'(CODE_LEN - 1));
        fail_inc   = (fail_count_q >= 4'(MAX_FAILS)) ? 4'(MAX_FAILS) : fail_count_q + 4'd1;

`ifdef LOCK_PROG_EN
        code_d      = code_q;
        shadow_d    = shadow_q;
        shadow_next = (shadow_q << DIGIT_W) | CODE_W'(digit);
`endif

        case (state_q)
            ST_IDLE, ST_ENTRY: begin
                if (clear) begin
                    state_d       = ST_IDLE;
                    digit_count_d = 3'd0;
                    mismatch_d    = 1'b0;
                end else if (enter) begin
                    if (last_digit) begin
                        digit_count_d = 3'd0;
                        mismatch_d    = 1'b0;
                        if (!final_mm) begin
                            state_d        = ST_UNLOCKED;
                            unlocked_d     = 1'b1;
                            fail_count_d   = 4'd0;
                            timer_load     = 1'b1;
                            timer_load_val = TMR_W'(RELOCK_CYCLES - 1);
                        end else begin
                            attempt_fail_d = 1'b1;
                            fail_count_d   = fail_inc;
                            if (fail_inc == 4'(MAX_FAILS)) begin
                                state_d        = ST_LOCKOUT;
                                locked_out_d   = 1'b1;
                                timer_load     = 1'b1;
                                timer_load_val = TMR_W'(LOCKOUT_CYCLES - 1);
                            end else begin
                                state_d = ST_IDLE;
                            end
                        end
                    end else begin
                        state_d       = ST_ENTRY;
                        digit_count_d = cnt_eff + 3'd1;
                        mismatch_d    = final_mm;
                    end
                end
            end

            ST_UNLOCKED: begin
                if (timer_zero || lock_req) begin
                    state_d    = ST_IDLE;
                    unlocked_d = 1'b0;
`ifdef LOCK_PROG_EN
                end else if (program_i) begin
                    // Door stays released while programming; relock timer is frozen.
                    state_d       = ST_PROG;
                    digit_count_d = 3'd0;
                    shadow_d      = '0;
`endif
                end else begin
                    timer_dec = 1'b1;
                end
            end

            ST_LOCKOUT: begin
                if (timer_zero) begin
                    state_d      = ST_IDLE;
                    locked_out_d = 1'b0;
                    fail_count_d = 4'd0;
                end else begin
                    timer_dec = 1'b1;
                end
            end

`ifdef LOCK_PROG_EN
            ST_PROG: begin
                if (clear || lock_req || (enter && digit_bad(digit))) begin
                    state_d       = ST_IDLE;
                    unlocked_d    = 1'b0;
                    digit_count_d = 3'd0;
                end else if (enter) begin
                    shadow_d = shadow_next;
                    if (prog_last) begin
                        code_d        = shadow_next;
                        state_d       = ST_IDLE;
                        unlocked_d    = 1'b0;
                        digit_count_d = 3'd0;
                    end else begin
                        digit_count_d = digit_count_q + 3'd1;
                    end
                end
            end
`endif

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= ST_IDLE;
            unlocked_q     <= 1'b0;
            locked_out_q   <= 1'b0;
            attempt_fail_q <= 1'b0;
            fail_count_q   <= 4'd0;
            digit_count_q  <= 3'd0;
            mismatch_q     <= 1'b0;
        end else begin
            state_q        <= state_d;
            unlocked_q     <= unlocked_d;
            locked_out_q   <= locked_out_d;
            attempt_fail_q <= attempt_fail_d;
            fail_count_q   <= fail_count_d;
            digit_count_q  <= digit_count_d;
            mismatch_q     <= mismatch_d;
        end
    end

`ifdef LOCK_PROG_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            code_q   <= CODE_DEFAULT;
            shadow_q <= '0;
        end else begin
            code_q   <= code_d;
            shadow_q <= shadow_d;
        end
    end
`endif

    assign unlocked     = unlocked_q;
    assign locked_out   = locked_out_q;
    assign attempt_fail = attempt_fail_q;
    assign fail_count   = fail_count_q;
    assign digit_count  = digit_count_q;
    assign state_dbg    = state_q;

endmodule
